// File: rtl/cpu_pkg.sv
// Shared types and widths for the 9-bit CPU front end.
//   PC_W      : PC / instruction memory address width
//   INSTR_W   : instruction width
//   LUT_IDX_W : branch-target LUT index width
//   CNT_W     : retired-instruction counter width
package cpu_pkg;

    localparam int unsigned PC_W      = 10;
    localparam int unsigned INSTR_W   = 9;
    localparam int unsigned LUT_IDX_W = 5;
    localparam int unsigned CNT_W     = 16;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [PC_W-1:0]    pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: maps the LUT index carried by a branch instruction
// to an absolute PC. Contents are fixed for the program build; entries not
// listed explicitly default to idx * 2**(PC_W-LUT_IDX_W).
//   idx_i    : LUT index from the current instruction
//   target_o : branch target PC (combinational)
module branch_lut
    import cpu_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] idx_i,
    output pc_t                  target_o
);

    // Program-specific targets override the evenly spaced default.
    always_comb begin
        target_o = pc_t'(idx_i) << (PC_W - LUT_IDX_W);
        case (idx_i)
            5'd2:    target_o = pc_t'(40);
            5'd3:    target_o = pc_t'(100);
            5'd31:   target_o = pc_t'(1000);
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 9-bit CPU. Holds the PC, drives the
// synchronous instruction ROM address, presents the fetched instruction to
// decode, applies branch/halt resolution from decode and runs the
// Start/Done program handshake.
// Optional feature macro: FETCH_STEP_EN adds single-step control inputs.
// Ports:
//   Clk, Reset_n   : clock (rising edge), asynchronous active-low reset
//   Start          : begin program at PC 0 (sampled in IDLE/DONE)
//   Step_en, Step  : (FETCH_STEP_EN only) step mode and step pulse
//   Branch_en/Branch_taken/Branch_idx/Halt : resolution from decode
//   imem_addr      : ROM address (combinational), data returns next cycle
//   imem_data      : ROM read data
//   mach_code      : instruction to decode (pass-through of imem_data)
//   instr_valid    : mach_code executes this cycle
//   PC             : address of mach_code
//   Instr_cnt      : retired instructions, saturating
//   Done, Err      : program finished; finished by PC overflow
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
`ifdef FETCH_STEP_EN
    input  logic                 Step_en,
    input  logic                 Step,
`endif
    input  logic                 Branch_en,
    input  logic                 Branch_taken,
    input  logic [LUT_IDX_W-1:0] Branch_idx,
    input  logic                 Halt,
    output pc_t                  imem_addr,
    input  instr_t               imem_data,
    output instr_t               mach_code,
    output logic                 instr_valid,
    output pc_t                  PC,
    output logic [CNT_W-1:0]     Instr_cnt,
    output logic                 Done,
    output logic                 Err
);

    fetch_state_t     state_q, state_d;
    pc_t              pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             step_ok;
    logic             take;
    pc_t              lut_target;
    pc_t              next_pc;
    pc_t              addr_c;
    logic             valid_c;

    // Whether the current RUN cycle is allowed to execute.
`ifdef FETCH_STEP_EN
    assign step_ok = !Step_en || Step;
`else
    assign step_ok = 1'b1;
`endif

    branch_lut u_lut (
        .idx_i    (Branch_idx),
        .target_o (lut_target)
    );

    assign take    = Branch_en && Branch_taken;
    assign next_pc = take ? lut_target : pc_q + pc_t'(1);

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, PC sequencing and ROM address.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        addr_c  = '0;
        valid_c = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (step_ok) begin
                    valid_c = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (Halt) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!take && (pc_q == '1)) begin
                        // Falling off the end of the ROM is an error, not a wrap.
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        // ROM sees next_pc now, so the target is valid next cycle.
                        pc_d   = next_pc;
                        addr_c = next_pc;
                    end
                end else begin
                    // Stalled step: re-fetch the current instruction.
                    addr_c = pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr   = addr_c;
    assign mach_code   = imem_data;
    assign instr_valid = valid_c;
    assign PC          = pc_q;
    assign Instr_cnt   = cnt_q;
    assign Done        = done_q;
    assign Err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit. Each ROM word encodes its own decode
// result: bit8 halt, bit7 branch_en, bit6 branch_taken, bits4:0 LUT index.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [8:0] OP_HALT = 9'h100;
    localparam logic [8:0] OP_BR   = 9'h080;
    localparam logic [8:0] OP_TK   = 9'h040;

    typedef struct packed {
        logic [9:0] pc;
        logic [8:0] code;
    } exp_t;

    typedef struct packed {
        logic        err;
        logic [15:0] cnt;
        logic [9:0]  pc;
    } end_t;

    logic                 Clk;
    logic                 Reset_n;
    logic                 Start;
    logic                 Step_en;
    logic                 Step;
    logic                 Branch_en;
    logic                 Branch_taken;
    logic [LUT_IDX_W-1:0] Branch_idx;
    logic                 Halt;
    pc_t                  imem_addr;
    instr_t               imem_data;
    instr_t               mach_code;
    logic                 instr_valid;
    pc_t                  PC;
    logic [CNT_W-1:0]     Instr_cnt;
    logic                 Done;
    logic                 Err;

    logic [8:0] rom [1024];
    exp_t       exp_q[$];
    end_t       end_q[$];
    exp_t       mon_e;
    end_t       mon_t;
    logic       done_prev;
    int         checks;
    int         errors;
    logic       step_mode;
    int         step_div;

    fetch_unit dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
`ifdef FETCH_STEP_EN
        .Step_en      (Step_en),
        .Step         (Step),
`endif
        .Branch_en    (Branch_en),
        .Branch_taken (Branch_taken),
        .Branch_idx   (Branch_idx),
        .Halt         (Halt),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .mach_code    (mach_code),
        .instr_valid  (instr_valid),
        .PC           (PC),
        .Instr_cnt    (Instr_cnt),
        .Done         (Done),
        .Err          (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous ROM model.
    always @(posedge Clk) imem_data <= rom[imem_addr];

    // Decode model: ungated by instr_valid on purpose.
    assign Halt         = mach_code[8];
    assign Branch_en    = mach_code[7];
    assign Branch_taken = mach_code[6];
    assign Branch_idx   = mach_code[4:0];

    // Step pulse every 3rd cycle when step mode is on.
    always @(negedge Clk) begin
        if (step_mode) begin
            Step     = (step_div == 2);
            step_div = (step_div + 1) % 3;
        end else begin
            Step     = 1'b0;
            step_div = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every valid instruction and on Done rising.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: PC %0d valid, nothing expected", PC);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pc", 32'(PC), 32'(mon_e.pc));
                    chk("mach_code", 32'(mach_code), 32'(mon_e.code));
                end
            end
            if (Done && !done_prev) begin
                if (end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: Done rose at PC %0d", PC);
                end else begin
                    mon_t = end_q.pop_front();
                    chk("done_err", 32'(Err), 32'(mon_t.err));
                    chk("done_cnt", 32'(Instr_cnt), 32'(mon_t.cnt));
                    chk("done_pc", 32'(PC), 32'(mon_t.pc));
                    chk("done_valid", 32'(instr_valid), 0);
                end
            end
        end
        done_prev = Done;
    end

    task automatic load_plain();
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i % 32);
    endtask

    task automatic push_pc(input int pc);
        exp_t e;
        e.pc   = 10'(pc);
        e.code = rom[pc];
        exp_q.push_back(e);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) push_pc(p);
    endtask

    task automatic push_end(input logic err, input int cnt, input int pc);
        end_t t;
        t.err = err;
        t.cnt = 16'(cnt);
        t.pc  = 10'(pc);
        end_q.push_back(t);
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic run(input string name, input int budget);
        int n;
        pulse_start();
        n = 0;
        while (!Done && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (!Done) begin
            errors++;
            $display("FAIL %s_timeout: Done=%0b after %0d cycles, expected 1", name, Done, n);
        end
        repeat (2) @(negedge Clk);
        chk({name, "_exp_drained"}, 32'(exp_q.size()), 0);
        chk({name, "_end_drained"}, 32'(end_q.size()), 0);
        exp_q.delete();
        end_q.delete();
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        Reset_n   = 1'b0;
        Start     = 1'b0;
        Step_en   = 1'b0;
        step_mode = 1'b0;
        step_div  = 0;
        done_prev = 1'b0;
        load_plain();
        repeat (3) @(negedge Clk);

        chk("rst_pc", 32'(PC), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_cnt", 32'(Instr_cnt), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("idle_valid", 32'(instr_valid), 0);

        // Linear code, halt at 5.
        load_plain();
        rom[5] = OP_HALT | 9'd5;
        push_range(0, 5);
        push_end(1'b0, 6, 5);
        run("linear", 30);

        // Taken branch at 3 through lut[2] = 40, halt at 41.
        load_plain();
        rom[3]  = OP_BR | OP_TK | 9'd2;
        rom[41] = OP_HALT;
        push_range(0, 3);
        push_range(40, 41);
        push_end(1'b0, 6, 41);
        run("br_taken", 30);

        // Branch not taken falls through.
        load_plain();
        rom[3] = OP_BR | 9'd2;
        rom[5] = OP_HALT;
        push_range(0, 5);
        push_end(1'b0, 6, 5);
        run("br_not_taken", 30);

        // Taken without Branch_en is ignored.
        load_plain();
        rom[3] = OP_TK | 9'd2;
        rom[5] = OP_HALT;
        push_range(0, 5);
        push_end(1'b0, 6, 5);
        run("tk_no_en", 30);

        // Halt beats a simultaneous taken branch.
        load_plain();
        rom[3]  = OP_HALT | OP_BR | OP_TK | 9'd2;
        rom[40] = OP_HALT;
        push_range(0, 3);
        push_end(1'b0, 4, 3);
        run("halt_vs_br", 30);

        // Branch word at address 0 is presented while not running; only
        // the executed copy redirects (lut[1] = 32).
        load_plain();
        rom[0]  = OP_BR | OP_TK | 9'd1;
        rom[33] = OP_HALT | 9'd1;
        repeat (4) @(negedge Clk);
        chk("done_hold_valid", 32'(instr_valid), 0);
        chk("done_hold_addr", 32'(imem_addr), 0);
        push_pc(0);
        push_range(32, 33);
        push_end(1'b0, 3, 33);
        run("br_at_0", 30);

        // Run off the end of the ROM, then restart cleanly.
        load_plain();
        push_range(0, 1023);
        push_end(1'b1, 1024, 1023);
        run("overflow", 1100);
        rom[2] = OP_HALT | 9'd2;
        push_range(0, 2);
        push_end(1'b0, 3, 2);
        run("restart", 30);
        chk("restart_err", 32'(Err), 0);

        // Asynchronous reset at PC 17.
        load_plain();
        push_range(0, 17);
        pulse_start();
        n = 0;
        while (PC != 10'd17 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_pc17", 32'(PC), 17);
        #1 Reset_n = 1'b0;
        #1;
        chk("arst_pc", 32'(PC), 0);
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_done", 32'(Done), 0);
        chk("arst_err", 32'(Err), 0);
        chk("arst_cnt", 32'(Instr_cnt), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_valid", 32'(instr_valid), 0);
        chk("post_rst_pc", 32'(PC), 0);
        chk("post_rst_exp_drained", 32'(exp_q.size()), 0);
        exp_q.delete();

`ifdef FETCH_STEP_EN
        // Step every 3rd cycle: one instruction per pulse.
        load_plain();
        rom[4]    = OP_HALT | 9'd4;
        Step_en   = 1'b1;
        step_mode = 1'b1;
        push_range(0, 4);
        push_end(1'b0, 5, 4);
        run("step", 60);
        step_mode = 1'b0;
        Step_en   = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
